// File: rtl/frame_tick_pkg.sv
// Shared types and constants for the frame tick scheduler.
// State encoding, divider floor and power-up configuration defaults.
// Imported by frame_tick_sched and bit_divider.
package frame_tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Smallest bit period that still yields a high and a low bit-clock phase.
  localparam int DIV_MIN       = 2;
  localparam int DIV_W_DEF     = 8;
  localparam int DIV_DEFAULT   = 21;
  localparam int WORD_BITS_DEF = 12;
  localparam int WORDS_W_DEF   = 8;
  localparam int WORDS_DEFAULT = 32;

endpackage

// File: rtl/bit_divider.sv
// Purpose: bit-period counter producing the bit clock and the end-of-bit strobe.
// Latency: outputs registered; clr_i makes the next cycle cnt=0 with bit_clk_o high.
// Backpressure: none; free-runs while en_i is high, returns to zero when idle.
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i restarts the count;
//        en_i advances the count; div_i bit period in cycles (>= 2);
//        bit_clk_o, bit_stb_o registered outputs; bit_stb_nxt_o next-cycle strobe.
import frame_tick_pkg::*;

module bit_divider #(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             bit_clk_o,
  output logic             bit_stb_o,
  output logic             bit_stb_nxt_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             bit_clk_q, bit_clk_d;
  logic             bit_stb_q, bit_stb_d;
  logic             active_d;
  logic [DIV_W-1:0] div_last;
  logic [DIV_W-1:0] div_half;

  assign div_last = div_i - 1'b1;
  assign div_half = div_i >> 1;

  // Outputs are decoded from the next count so they line up with the count
  // value that the register will hold during the same cycle.
  always_comb begin
    cnt_d = '0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == div_last) ? '0 : cnt_q + 1'b1;
    end
    active_d  = clr_i | en_i;
    bit_clk_d = active_d && (cnt_d < div_half);
    bit_stb_d = active_d && (cnt_d == div_last);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      bit_clk_q <= 1'b0;
      bit_stb_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_clk_q <= bit_clk_d;
      bit_stb_q <= bit_stb_d;
    end
  end

  assign bit_clk_o     = bit_clk_q;
  assign bit_stb_o     = bit_stb_q;
  assign bit_stb_nxt_o = bit_stb_d;

endmodule

// File: rtl/frame_tick_sched.sv
// Purpose: bit/word/frame timing scheduler with start/stop control and config capture.
// Latency: start sampled at edge N -> ARM at N+1, RUN from N+2; all outputs registered.
// Backpressure: config accepted only in IDLE (oCfgReady); stop honoured on frame boundary.
// Ports: clk100MHz/rst clock and async active-low reset; iCfgValid/oCfgReady/iCfgDiv/
//        iCfgWords config handshake; iStart/iStop level requests; oBitClk, oBitStb,
//        oWordStb, oFrameStb timing outputs; oBitIdx/oWordIdx positions; oBusy not IDLE.
import frame_tick_pkg::*;

module frame_tick_sched #(
  parameter int DIV_W         = DIV_W_DEF,
  parameter int DIV_DEFAULT   = frame_tick_pkg::DIV_DEFAULT,
  parameter int WORD_BITS     = WORD_BITS_DEF,
  parameter int WORDS_W       = WORDS_W_DEF,
  parameter int WORDS_DEFAULT = frame_tick_pkg::WORDS_DEFAULT
) (
  input  logic               clk100MHz,
  input  logic               rst,
  input  logic               iCfgValid,
  output logic               oCfgReady,
  input  logic [DIV_W-1:0]   iCfgDiv,
  input  logic [WORDS_W-1:0] iCfgWords,
  input  logic               iStart,
  input  logic               iStop,
  output logic               oBitClk,
  output logic               oBitStb,
  output logic               oWordStb,
  output logic               oFrameStb,
  output logic [3:0]         oBitIdx,
  output logic [WORDS_W-1:0] oWordIdx,
  output logic               oBusy
);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [WORDS_W-1:0] words_q, words_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [WORDS_W-1:0] word_idx_q, word_idx_d;
  logic               word_stb_q, word_stb_d;
  logic               frame_stb_q, frame_stb_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               cnt_clr, cnt_en, running;
  logic               bit_clk, bit_stb, bit_stb_nxt;
  logic [DIV_W-1:0]   cfg_div_clamped;
  logic [WORDS_W-1:0] cfg_words_clamped;

  assign cfg_div_clamped   = (iCfgDiv < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : iCfgDiv;
  assign cfg_words_clamped = (iCfgWords == '0) ? WORDS_W'(1) : iCfgWords;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    words_d = words_q;
    case (state_q)
      ST_IDLE: begin
        if (iCfgValid && ready_q) begin
          div_d   = cfg_div_clamped;
          words_d = cfg_words_clamped;
        end
        // Simultaneous start and stop: stop wins.
        if (iStart && !iStop) state_d = ST_ARM;
      end
      ST_ARM:   state_d = ST_RUN;
      // A stop landing on the last cycle of a frame skips DRAIN entirely.
      ST_RUN:   if (iStop) state_d = frame_stb_q ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (frame_stb_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    running = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    cnt_clr = (state_q == ST_ARM);
    // Counting stops on the edge that leaves for IDLE so every output drops together.
    cnt_en  = running && (state_d != ST_IDLE);

    bit_idx_d  = '0;
    word_idx_d = '0;
    if (cnt_en) begin
      bit_idx_d  = bit_idx_q;
      word_idx_d = word_idx_q;
      if (bit_stb) begin
        bit_idx_d = (bit_idx_q == 4'(WORD_BITS - 1)) ? 4'd0 : bit_idx_q + 4'd1;
      end
      if (word_stb_q) begin
        word_idx_d = (word_idx_q == words_q - 1'b1) ? '0 : word_idx_q + 1'b1;
      end
    end

    // Strobes are registered, so decode them from the next-cycle bit strobe and indices.
    word_stb_d  = bit_stb_nxt && (bit_idx_d == 4'(WORD_BITS - 1));
    frame_stb_d = word_stb_d && (word_idx_d == words_q - 1'b1);
    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      div_q       <= DIV_W'(DIV_DEFAULT);
      words_q     <= WORDS_W'(WORDS_DEFAULT);
      bit_idx_q   <= '0;
      word_idx_q  <= '0;
      word_stb_q  <= 1'b0;
      frame_stb_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      words_q     <= words_d;
      bit_idx_q   <= bit_idx_d;
      word_idx_q  <= word_idx_d;
      word_stb_q  <= word_stb_d;
      frame_stb_q <= frame_stb_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  bit_divider #(
    .DIV_W (DIV_W)
  ) u_bit_divider (
    .clk_i         (clk100MHz),
    .rst_ni        (rst),
    .clr_i         (cnt_clr),
    .en_i          (cnt_en),
    .div_i         (div_q),
    .bit_clk_o     (bit_clk),
    .bit_stb_o     (bit_stb),
    .bit_stb_nxt_o (bit_stb_nxt)
  );

  assign oCfgReady = ready_q;
  assign oBusy     = busy_q;
  assign oBitClk   = bit_clk;
  assign oBitStb   = bit_stb;
  assign oWordStb  = word_stb_q;
  assign oFrameStb = frame_stb_q;
  assign oBitIdx   = bit_idx_q;
  assign oWordIdx  = word_idx_q;

endmodule

// File: tb/tb_frame_tick_sched.sv
// Bench for frame_tick_sched: directed scenarios plus randomized traffic, every cycle
// compared against an arithmetic model of elapsed time since RUN entry.
// Output vector order: {ready, busy, bitclk, bitstb, wordstb, framestb, bitidx[3:0], wordidx[7:0]}.
module tb_frame_tick_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_vld = 1'b0;
  logic       cfg_rdy;
  logic [7:0] cfg_div = '0;
  logic [7:0] cfg_words = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       bit_clk, bit_stb, word_stb, frame_stb, busy;
  logic [3:0] bit_idx;
  logic [7:0] word_idx;

  always #5 clk = ~clk;

  frame_tick_sched dut (
    .clk100MHz (clk),
    .rst       (rst),
    .iCfgValid (cfg_vld),
    .oCfgReady (cfg_rdy),
    .iCfgDiv   (cfg_div),
    .iCfgWords (cfg_words),
    .iStart    (start),
    .iStop     (stop),
    .oBitClk   (bit_clk),
    .oBitStb   (bit_stb),
    .oWordStb  (word_stb),
    .oFrameStb (frame_stb),
    .oBitIdx   (bit_idx),
    .oWordIdx  (word_idx),
    .oBusy     (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: what the DUT shows in the next cycle to be observed.
  bit m_busy = 0, m_arm = 0, m_stopping = 0;
  int m_t = 0, m_div = 21, m_words = 32;

  // Observation bookkeeping.
  int arm_cyc, hi_cnt, bs_cnt, ws_cnt, fs_cnt;
  int last_b, prev_b, last_w, prev_w, last_f, prev_f, busy_fall;
  bit prev_busy = 0;

  function automatic logic [17:0] m_exp();
    int c, bi, wi;
    logic clk_e, bs, ws, fs;
    if (!m_busy) return 18'h20000;
    if (m_arm) return 18'h10000;
    c  = m_t % m_div;
    bi = (m_t / m_div) % 12;
    wi = (m_t / (12 * m_div)) % m_words;
    clk_e = (c < m_div / 2);
    bs = (c == m_div - 1);
    ws = bs && (bi == 11);
    fs = ws && (wi == m_words - 1);
    return {1'b0, 1'b1, clk_e, bs, ws, fs, 4'(bi), 8'(wi)};
  endfunction

  function automatic bit m_fstb();
    logic [17:0] e;
    e = m_exp();
    return e[12];
  endfunction

  function automatic logic [17:0] obs();
    return {cfg_rdy, busy, bit_clk, bit_stb, word_stb, frame_stb, bit_idx, word_idx};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic clr_counts();
    hi_cnt = 0; bs_cnt = 0; ws_cnt = 0; fs_cnt = 0;
    last_b = 0; prev_b = 0; last_w = 0; prev_w = 0; last_f = 0; prev_f = 0;
    busy_fall = 0;
  endtask

  // One cycle: check the current outputs, drive inputs for the next edge, advance model.
  task automatic step(input bit v, input int d, input int w, input bit st, input bit sp);
    logic [17:0] e;
    @(negedge clk);
    e = m_exp();
    chk("cycle", 32'(obs()), 32'(e));
    if (bit_clk) hi_cnt++;
    if (bit_stb) begin bs_cnt++; prev_b = last_b; last_b = cyc; end
    if (word_stb) begin ws_cnt++; prev_w = last_w; last_w = cyc; end
    if (frame_stb) begin fs_cnt++; prev_f = last_f; last_f = cyc; end
    if (prev_busy && !busy) busy_fall = cyc;
    prev_busy = busy;
    cfg_vld = v; cfg_div = 8'(d); cfg_words = 8'(w); start = st; stop = sp;
    if (!m_busy) begin
      if (v) begin
        m_div   = (d < 2) ? 2 : d;
        m_words = (w == 0) ? 1 : w;
      end
      if (st && !sp) begin
        m_busy = 1; m_arm = 1; arm_cyc = cyc + 1;
      end
    end else if (m_arm) begin
      m_arm = 0; m_t = 0; m_stopping = 0;
    end else if (e[12] && (m_stopping || sp)) begin
      m_busy = 0;
    end else begin
      if (sp) m_stopping = 1;
      m_t++;
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20000 && m_busy; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic run_default_frame(input string tag);
    clr_counts();
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 200; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    drain();
    chk({tag, "_frame_lat"}, 32'(last_f - arm_cyc), 32'd8064);
    chk({tag, "_bitclk_hi"}, 32'(hi_cnt), 32'd3840);
    chk({tag, "_bitstb_n"}, 32'(bs_cnt), 32'd384);
    chk({tag, "_wordstb_n"}, 32'(ws_cnt), 32'd32);
    chk({tag, "_bit_per"}, 32'(last_b - prev_b), 32'd21);
    chk({tag, "_word_per"}, 32'(last_w - prev_w), 32'd252);
    chk({tag, "_busy_fall"}, 32'(busy_fall - last_f), 32'd1);
  endtask

  initial begin
    // Reset state.
    #12;
    chk("reset_vals", 32'(obs()), 32'h20000);
    @(negedge clk);
    rst = 1'b1;

    // Default configuration, full frame.
    run_default_frame("dflt");

    // div=5 words=2, stop during word 0: full frame still completes.
    clr_counts();
    step(1, 5, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    drain();
    chk("d5w2_frame_lat", 32'(last_f - arm_cyc), 32'd120);
    chk("d5w2_frames", 32'(fs_cnt), 32'd1);
    chk("d5w2_busy_fall", 32'(busy_fall - last_f), 32'd1);

    // Clamp: div=0, words=0 -> 2-cycle bits, 12-bit frames.
    clr_counts();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 80; i++) step(0, 0, 0, 0, 0);
    chk("clamp_frame_per", 32'(last_f - prev_f), 32'd24);
    chk("clamp_bit_per", 32'(last_b - prev_b), 32'd2);
    drain();

    // Config offered while running is refused and does not disturb the period.
    clr_counts();
    step(1, 7, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 0);
    step(1, 9, 4, 0, 0);
    chk("cfg_rdy_in_run", 32'(cfg_rdy), 32'd0);
    for (int i = 0; i < 30; i++) step(1, 9, 4, 0, 0);
    chk("run_bit_per_kept", 32'(last_b - prev_b), 32'd7);
    drain();
    clr_counts();
    step(1, 9, 4, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0);
    chk("new_bit_per", 32'(last_b - prev_b), 32'd9);

    // Reset at word 3 bit 5 of the div=9 run.
    for (int i = 0; i < 2000 && !(m_busy && !m_arm && m_t == 41 * 9); i++) step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_bit", 32'(bit_idx), 32'd5);
    chk("pre_rst_word", 32'(word_idx), 32'd3);
    #2 rst = 1'b0;
    #1 chk("midrun_reset", 32'(obs()), 32'h20000);
    cfg_vld = 0; start = 0; stop = 0;
    m_busy = 0; m_arm = 0; m_div = 21; m_words = 32;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_default_frame("restart");

    // Start and stop together in IDLE: stop wins.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
    chk("start_stop_busy", 32'(busy), 32'd0);

    // Stop raised exactly on a frame strobe in RUN: straight to IDLE after that frame.
    clr_counts();
    step(1, 2, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 200 && m_busy; i++) step(0, 0, 0, 0, m_fstb());
    step(0, 0, 0, 0, 0);
    chk("stop_on_frame_n", 32'(fs_cnt), 32'd1);
    chk("stop_on_frame_fall", 32'(busy_fall - last_f), 32'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 25 && errors < 20; k++) begin
      int n;
      step(1, $urandom_range(0, 12), $urandom_range(0, 3), 0, 0);
      step(0, 0, 0, 1, $urandom_range(0, 3) == 0);
      n = $urandom_range(5, 300);
      for (int i = 0; i < n && errors < 20; i++)
        step($urandom_range(0, 7) == 0, $urandom_range(0, 12), $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
